// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared constants and helpers for the pipelined add/subtract unit.
//   ADD / SUB       : values of the 'sub' mode input
//   width_ok()      : legality check of a WIDTH / STAGES pairing, used at
//                     elaboration so an illegal slice split never builds
// ----------------------------------------------------------------------------
package adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // A pairing is legal when every slice gets the same whole number of bits.
    function automatic bit width_ok(input int width, input int stages);
        if (stages < 1 || stages > width) begin
            return 1'b0;
        end
        return (width % stages) == 0;
    endfunction

endpackage

// File: rtl/adder_nbit_pipe_if.sv
// ----------------------------------------------------------------------------
// adder_nbit_pipe_if
// Operand/result bundle of the pipelined adder.
//   en         : pipeline advance enable (global stall when low)
//   in_valid   : a, b, carry_in, sub form a valid operation
//   a, b       : operands, WIDTH bits
//   carry_in   : carry into bit 0 in add mode
//   sub        : mode select (adder_pkg::ADD / adder_pkg::SUB)
//   out_valid  : sum, carry_out, overflow hold a completed result
//   sum        : result modulo 2^WIDTH
//   carry_out  : carry out of the MSB (no-borrow flag in subtract mode)
//   overflow   : two's-complement overflow
// Modports: master = operand producer / result consumer, slave = the adder.
// ----------------------------------------------------------------------------
interface adder_nbit_pipe_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output en, in_valid, a, b, carry_in, sub,
        input  out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  en, in_valid, a, b, carry_in, sub,
        output out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/adder_1bit.sv
// ----------------------------------------------------------------------------
// adder_1bit
// Full-adder cell.
//   a, b       : operand bits
//   carry_in   : incoming carry
//   sum        : a ^ b ^ carry_in
//   carry_out  : majority of the three inputs
// ----------------------------------------------------------------------------
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    logic half_sum;

    assign half_sum  = a ^ b;
    assign sum       = half_sum ^ carry_in;
    assign carry_out = (a & b) | (carry_in & half_sum);
endmodule

// File: rtl/adder_slice.sv
// ----------------------------------------------------------------------------
// adder_slice
// CHUNK-bit combinational ripple adder built from adder_1bit cells; one
// instance forms one pipeline slice of adder_nbit_pipe.
//   a, b          : slice operand bits (b already inverted for subtract)
//   carry_in      : carry into the slice LSB
//   sum           : slice sum bits
//   carry_out     : carry out of the slice MSB
//   msb_carry_in  : carry into the slice MSB (overflow tap of the top slice)
// ----------------------------------------------------------------------------
module adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out,
    output logic             msb_carry_in
);
    // Each bit owns its carry nets, so the chain is a series of distinct
    // signals rather than one vector feeding back into itself.
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic c_in;
        logic c_out;

        if (i == 0) begin : g_cin
            assign c_in = carry_in;
        end else begin : g_cin
            assign c_in = g_bit[i-1].c_out;
        end

        adder_1bit u_bit (
            .a         (a[i]),
            .b         (b[i]),
            .carry_in  (c_in),
            .sum       (sum[i]),
            .carry_out (c_out)
        );
    end

    assign carry_out    = g_bit[CHUNK-1].c_out;
    assign msb_carry_in = g_bit[CHUNK-1].c_in;
endmodule

// File: rtl/adder_nbit_pipe.sv
// ----------------------------------------------------------------------------
// adder_nbit_pipe
// Pipelined WIDTH-bit add/subtract unit. The carry chain is cut into STAGES
// slices of CHUNK = WIDTH/STAGES bits with a register bank after each slice.
// Latency is STAGES enabled edges, throughput one operation per enabled edge.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset, clears every pipeline register
//   bus   : adder_nbit_pipe_if.slave (en, in_valid, a, b, carry_in, sub in;
//           out_valid, sum, carry_out, overflow out)
// ----------------------------------------------------------------------------
module adder_nbit_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    adder_nbit_pipe_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    if (!width_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("adder_nbit_pipe: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Subtract is A + ~B + 1: invert B once at the input, force carry-in.
    logic [WIDTH-1:0] op_b;
    logic             op_cin;

    assign op_b   = (bus.sub == SUB) ? ~bus.b : bus.b;
    assign op_cin = (bus.sub == ADD) ? bus.carry_in : 1'b1;

    // Outputs of the top slice, registered into the interface below.
    logic [WIDTH-1:0] fin_sum;
    logic             fin_cout;
    logic             fin_msb_cin;
    logic             fin_valid;

    // Stage k works on bits [k*CHUNK +: CHUNK]. Its bank k carries forward
    // the still-unsummed upper operand bits (skew), the finished lower sum
    // bits (de-skew), the slice carry and the valid bit. The last stage has
    // no bank of its own; it feeds the output registers directly.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * CHUNK;
        localparam int REM = WIDTH - LO - CHUNK;

        logic [WIDTH-LO-1:0] rem_a;
        logic [WIDTH-LO-1:0] rem_b;
        logic [LO+CHUNK-1:0] sum_acc;
        logic [CHUNK-1:0]    s_sum;
        logic                s_cin;
        logic                s_cout;
        logic                s_msb_cin;
        logic                s_valid;

        if (k == 0) begin : g_src
            assign rem_a   = bus.a;
            assign rem_b   = op_b;
            assign s_cin   = op_cin;
            assign s_valid = bus.in_valid;
            assign sum_acc = s_sum;
        end else begin : g_src
            assign rem_a   = g_stage[k-1].g_bank.a_q;
            assign rem_b   = g_stage[k-1].g_bank.b_q;
            assign s_cin   = g_stage[k-1].g_bank.carry_q;
            assign s_valid = g_stage[k-1].g_bank.valid_q;
            assign sum_acc = {s_sum, g_stage[k-1].g_bank.sum_q};
        end

        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a            (rem_a[CHUNK-1:0]),
            .b            (rem_b[CHUNK-1:0]),
            .carry_in     (s_cin),
            .sum          (s_sum),
            .carry_out    (s_cout),
            .msb_carry_in (s_msb_cin)
        );

        if (k < STAGES - 1) begin : g_bank
            logic [REM-1:0]      a_q;
            logic [REM-1:0]      b_q;
            logic [LO+CHUNK-1:0] sum_q;
            logic                carry_q;
            logic                valid_q;
            // Only the top slice's MSB carry is the overflow tap.
            logic                msb_cin_unused;

            assign msb_cin_unused = s_msb_cin;

            // Bubbles advance like real operations; only valid_q tells them
            // apart, so the data registers need no valid gating.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    sum_q   <= '0;
                    carry_q <= 1'b0;
                    valid_q <= 1'b0;
                end else if (bus.en) begin
                    a_q     <= rem_a[WIDTH-LO-1:CHUNK];
                    b_q     <= rem_b[WIDTH-LO-1:CHUNK];
                    sum_q   <= sum_acc;
                    carry_q <= s_cout;
                    valid_q <= s_valid;
                end
            end
        end else begin : g_last
            assign fin_sum     = sum_acc;
            assign fin_cout    = s_cout;
            assign fin_msb_cin = s_msb_cin;
            assign fin_valid   = s_valid;
        end
    end

    // Result registers only load on a valid result so a bubble leaves the
    // last answer visible; en low freezes everything including out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.carry_out <= 1'b0;
            bus.overflow  <= 1'b0;
        end else if (bus.en) begin
            bus.out_valid <= fin_valid;
            if (fin_valid) begin
                bus.sum       <= fin_sum;
                bus.carry_out <= fin_cout;
                bus.overflow  <= fin_cout ^ fin_msb_cin;
            end
        end
    end
endmodule
